mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory-side responder for the load/store buffer's byte-wide RAM port: it samples `ram_addr`/`ram_writing`/`ram_data` and returns `ram_loaded_data` one edge later. It contains the byte-addressed main RAM, a program-preload port, and a memory-mapped output device (8-entry TX FIFO feeding an 8N1 UART transmitter). It sits between the LSB and the board pins.

## Interface
- `ADDR_WIDTH`, 17: RAM holds 2^ADDR_WIDTH bytes.
- `IO_DATA`, 32'h0003_0000: write pushes one byte to TX FIFO.
- `IO_STATUS`, 32'h0003_0004: read-only status byte.
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two.
- `BAUD_DIV`, 16: clk cycles per UART bit, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `ram_addr` in 32: byte address from LSB.
- `ram_writing` in 1: 1 = write `ram_data` at `ram_addr` this cycle.
- `ram_data` in 8: write byte.
- `ram_loaded_data` out 8: read byte for the address sampled at the previous posedge.
- `load_en` in 1: preload write strobe.
- `load_addr` in ADDR_WIDTH: preload address.
- `load_data` in 8: preload byte.
- `io_full` out 1: TX FIFO holds FIFO_DEPTH entries.
- `tx_busy` out 1: FIFO non-empty or transmitter not IDLE.
- `uart_tx` out 1: serial line, idles high.

## Operation
- All state updates on posedge clk. The LSB drives on negedge, so inputs are stable at posedge.
- Decode per cycle, on `ram_addr`:
  - RAM: `ram_addr < 2^ADDR_WIDTH`.
  - IO_DATA / IO_STATUS: exact match.
  - Everything else is unmapped.
- Read (every cycle, regardless of `ram_writing`):
  - RAM → `mem[addr]`. Read-first: a write to the same address in the same cycle returns the old byte.
  - IO_STATUS → {5'b0, overflow, tx_busy, io_full}, using values before the edge.
  - IO_DATA and unmapped → 8'h00.
- Write (`ram_writing`=1):
  - RAM: stores the byte.
  - IO_DATA: pushes the byte. The push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and sticky `overflow` is set.
  - IO_STATUS and unmapped: ignored.
- Preload: `load_en`=1 writes `load_data` to `mem[load_addr]`. A simultaneous `ram_writing` RAM write is discarded that cycle. IO pushes and reads are unaffected.
- FIFO: circular, head/tail pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH. `io_full` is registered from the next count.
- UART FSM:
  - IDLE: `uart_tx`=1. If count>0, pop the head into the shift register and go to START.
  - START: `uart_tx`=0 for BAUD_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each, then STOP.
  - STOP: `uart_tx`=1 for BAUD_DIV cycles, then IDLE.
- `overflow` is cleared only by reset.

## Timing
- Reset values (RAM contents not cleared):
  - `ram_loaded_data`=0, `uart_tx`=1, `io_full`=0, `tx_busy`=0.
  - FIFO empty, `overflow`=0, FSM IDLE, baud counter 0.
- Read latency: address sampled at posedge N; data valid from N until posedge N+1. Consecutive-cycle reads are fully pipelined.
- Write latency: RAM write visible to a read sampled at posedge N+1.
- FIFO push at edge N → pop possible at edge N+1, when the IDLE check sees count>0. START drives `uart_tx`=0 from edge N+2.
- Frame length is 10·BAUD_DIV cycles. Back-to-back frames are separated by exactly 1 IDLE cycle (the pop cycle).
- `tx_busy` is registered: 1 from the push edge until the edge returning to IDLE with an empty FIFO.
- Reset mid-frame: frame aborted; `uart_tx`=1 and FIFO empty on the reset edge. Reset mid-read: `ram_loaded_data`=0 at that edge.

## Test plan
- Preload 0x13,0x00,0x00,0x00 at 0..3, then read addr 0,1,2,3 on consecutive cycles → `ram_loaded_data` = 13,00,00,00, each one edge after its address.
- Write 0xAB to addr 0x10 and read 0x10 in the same cycle → old byte; next-cycle read → 0xAB.
- Write 0x55 to IO_DATA with BAUD_DIV=16 → `uart_tx` low 16 cycles, then bits 1,0,1,0,1,0,1,0, then high 16 cycles; `tx_busy` falls after 160+1 cycles.
- 9 IO writes on consecutive cycles → first pops after 1 cycle; `io_full` asserts after the 9th write pushes count to 8; no overflow. A 10th write while full with no pop → dropped; IO_STATUS read returns bit2=1.
- Read IO_STATUS while idle → 0x00; unmapped read 0x0002_0000 → 0x00; unmapped write has no effect on RAM addr 0.
- Assert rst mid-DATA phase → `uart_tx`=1, `tx_busy`=0, `io_full`=0 next edge; preloaded RAM bytes still read back intact.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// Bundles the LSB RAM port, the program-preload port and the board-side UART/status pins.
// The master is the LSB/board side. The slave is the responder.
// Read data, status and UART outputs are all registered inside the responder.
interface mem_io_responder_if #(
   parameter int unsigned ADDR_WIDTH = 17
);
   logic [31:0]           ram_addr;
   logic                  ram_writing;
   logic [7:0]            ram_data;
   logic [7:0]            ram_loaded_data;
   logic                  load_en;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [7:0]            load_data;
   logic                  io_full;
   logic                  tx_busy;
   logic                  uart_tx;

   modport master (
      output ram_addr, ram_writing, ram_data, load_en, load_addr, load_data,
      input  ram_loaded_data, io_full, tx_busy, uart_tx
   );

   modport slave (
      input  ram_addr, ram_writing, ram_data, load_en, load_addr, load_data,
      output ram_loaded_data, io_full, tx_busy, uart_tx
   );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM + preload port + memory-mapped TX FIFO driving an 8N1 UART, serving the LSB RAM port.
// Latency: read data registered one edge after the address. The UART line lags the FSM state by one edge.
// Backpressure: none; IO_DATA writes to a full FIFO with no pop that cycle are dropped and set sticky overflow.
module mem_io_responder #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter logic [31:0] IO_DATA    = 32'h0003_0000,
   parameter logic [31:0] IO_STATUS  = 32'h0003_0004,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned BAUD_DIV   = 16
) (
   input logic               clk,
   input logic               rst,
   mem_io_responder_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   logic [7:0]            mem_q [0:(1<<ADDR_WIDTH)-1];
   logic [7:0]            fifo_q [0:FIFO_DEPTH-1];

   logic [7:0]            rd_q, rd_d;
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  full_q, full_d;
   logic                  busy_q, busy_d;
   logic                  uart_tx_q, uart_tx_d;
   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;

   logic                  is_ram, is_io_data, is_io_status;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic                  pop, push_req, push_ok, baud_end;

   assign is_ram       = (bus.ram_addr >> ADDR_WIDTH) == 32'd0;
   assign is_io_data   = bus.ram_addr == IO_DATA;
   assign is_io_status = bus.ram_addr == IO_STATUS;
   assign ram_idx      = bus.ram_addr[ADDR_WIDTH-1:0];
   assign baud_end     = baud_q == BAUD_W'(BAUD_DIV - 1);

   assign bus.ram_loaded_data = rd_q;
   assign bus.io_full         = full_q;
   assign bus.tx_busy         = busy_q;
   assign bus.uart_tx         = uart_tx_q;

   // Read mux: old RAM byte (read-first) or the pre-edge status flags.
   always_comb begin
      rd_d = 8'h00;
      if (is_ram) begin
         rd_d = mem_q[ram_idx];
      end else if (is_io_status) begin
         rd_d = {5'b0, ovf_q, busy_q, full_q};
      end
   end

   // RAM write port: preload wins over a same-cycle LSB write; contents survive reset.
   always_ff @(posedge clk) begin
      if (bus.load_en) begin
         mem_q[bus.load_addr] <= bus.load_data;
      end else if (bus.ram_writing && is_ram) begin
         mem_q[ram_idx] <= bus.ram_data;
      end
   end

   // FIFO storage: accepted IO_DATA bytes land at the tail.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_q[tail_q] <= bus.ram_data;
      end
   end

   // UART FSM next state: pop in IDLE, then START, 8 data bits LSB first, STOP.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      uart_tx_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = fifo_q[head_q];
               baud_d  = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            uart_tx_d = 1'b0;
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            uart_tx_d = shift_q[0];
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO bookkeeping: a push into a full FIFO is only accepted when the FSM pops this same cycle.
   always_comb begin
      push_req = bus.ram_writing && is_io_data;
      push_ok  = push_req && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      head_d   = pop ? head_q + PTR_W'(1) : head_q;
      tail_d   = push_ok ? tail_q + PTR_W'(1) : tail_q;
      ovf_d    = ovf_q | (push_req & ~push_ok);
      full_d   = count_d == CNT_W'(FIFO_DEPTH);
      busy_d   = (count_d != '0) || (state_d != ST_IDLE);
   end

   // Control state register with synchronous active-low reset; aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_q      <= 8'h00;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         full_q    <= 1'b0;
         busy_q    <= 1'b0;
         uart_tx_q <= 1'b1;
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
      end else begin
         rd_q      <= rd_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         full_q    <= full_d;
         busy_q    <= busy_d;
         uart_tx_q <= uart_tx_d;
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
      end
   end
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed stimulus, a frame-timer/queue reference model
// compared every cycle, and hand-computed literal checks at the interesting points.
module tb_mem_io_responder;
   localparam int          AW        = 17;
   localparam int          B         = 16;
   localparam int          D         = 8;
   localparam logic [31:0] IO_DATA   = 32'h0003_0000;
   localparam logic [31:0] IO_STATUS = 32'h0003_0004;
   localparam logic [31:0] UNMAPPED  = 32'h0002_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_io_responder_if #(.ADDR_WIDTH(AW)) bus();

   mem_io_responder #(
      .ADDR_WIDTH(AW), .IO_DATA(IO_DATA), .IO_STATUS(IO_STATUS),
      .FIFO_DEPTH(D), .BAUD_DIV(B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: RAM as a sparse map, TX FIFO as a queue, the transmitter
   // as a frame timer m_t counting cycles since the pop edge.
   logic [7:0] m_mem [int];
   logic [7:0] m_q [$];
   bit         m_active = 0;
   int         m_t = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_ovf = 0, m_busy = 0, m_full = 0, m_tx = 1;
   logic [7:0] m_rd = 8'h00;
   bit         m_rd_known = 0;
   bit         m_valid = 0;

   always @(posedge clk) begin
      logic [7:0] rd_n;
      bit         known_n;
      bit         tx_n;
      bit         pop;
      int         idx;
      if (!rst) begin
         m_q.delete();
         m_active   = 0;
         m_t        = 0;
         m_ovf      = 0;
         m_busy     = 0;
         m_full     = 0;
         m_rd       = 8'h00;
         m_rd_known = 1;
         m_tx       = 1;
      end else begin
         known_n = 1;
         rd_n    = 8'h00;
         if (bus.ram_addr < (32'd1 << AW)) begin
            if (m_mem.exists(int'(bus.ram_addr))) rd_n = m_mem[int'(bus.ram_addr)];
            else known_n = 0;
         end else if (bus.ram_addr == IO_STATUS) begin
            rd_n = {5'b0, m_ovf, m_busy, m_full};
         end
         // Line level follows the frame position as it stood before this edge.
         if (m_active) begin
            idx = m_t / B;
            if (idx == 0) tx_n = 0;
            else if (idx <= 8) tx_n = m_byte[idx-1];
            else tx_n = 1;
         end else begin
            tx_n = 1;
         end
         pop = !m_active && (m_q.size() > 0);
         if (m_active) begin
            m_t++;
            if (m_t == 10 * B) m_active = 0;
         end
         if (pop) begin
            m_byte   = m_q.pop_front();
            m_active = 1;
            m_t      = 0;
         end
         if (bus.ram_writing && bus.ram_addr == IO_DATA) begin
            if (m_q.size() < D) m_q.push_back(bus.ram_data);
            else m_ovf = 1;
         end
         m_full     = (m_q.size() == D);
         m_busy     = (m_q.size() > 0) || m_active;
         m_rd       = rd_n;
         m_rd_known = known_n;
         m_tx       = tx_n;
      end
      if (bus.load_en) m_mem[int'(bus.load_addr)] = bus.load_data;
      else if (bus.ram_writing && bus.ram_addr < (32'd1 << AW)) m_mem[int'(bus.ram_addr)] = bus.ram_data;
      m_valid = 1;
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         if (m_rd_known) chk("model ram_loaded_data", {24'b0, bus.ram_loaded_data}, {24'b0, m_rd});
         chk("model uart_tx", {31'b0, bus.uart_tx}, {31'b0, m_tx});
         chk("model tx_busy", {31'b0, bus.tx_busy}, {31'b0, m_busy});
         chk("model io_full", {31'b0, bus.io_full}, {31'b0, m_full});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] pre [4];
   logic       bits55 [8];

   initial begin
      pre    = '{8'h13, 8'h00, 8'h00, 8'h00};
      bits55 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      bus.ram_addr    = 32'h0;
      bus.ram_writing = 1'b0;
      bus.ram_data    = 8'h00;
      bus.load_en     = 1'b0;
      bus.load_addr   = '0;
      bus.load_data   = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset ram_loaded_data", {24'b0, bus.ram_loaded_data}, 32'h00);
      chk("reset uart_tx", {31'b0, bus.uart_tx}, 32'h1);
      chk("reset tx_busy", {31'b0, bus.tx_busy}, 32'h0);
      chk("reset io_full", {31'b0, bus.io_full}, 32'h0);
      rst = 1'b1;

      // Preload program bytes plus a known byte at 0x10
      for (int i = 0; i < 4; i++) begin
         bus.load_en = 1'b1; bus.load_addr = AW'(i); bus.load_data = pre[i];
         @(negedge clk);
      end
      bus.load_addr = AW'(16'h0010); bus.load_data = 8'h5A;
      @(negedge clk);
      // Preload collides with an LSB RAM write to the same address
      bus.load_addr = AW'(16'h0020); bus.load_data = 8'h11;
      bus.ram_writing = 1'b1; bus.ram_addr = 32'h20; bus.ram_data = 8'h22;
      @(negedge clk);
      bus.load_en = 1'b0; bus.ram_writing = 1'b0;

      // Pipelined reads of the preloaded bytes
      for (int i = 0; i < 4; i++) begin
         bus.ram_addr = 32'(i);
         @(negedge clk);
         chk($sformatf("preload read addr %0d", i), {24'b0, bus.ram_loaded_data}, {24'b0, pre[i]});
      end
      bus.ram_addr = 32'h20;
      @(negedge clk);
      chk("preload beats ram write", {24'b0, bus.ram_loaded_data}, 32'h11);

      // Read-first on a same-cycle write, then the new byte
      bus.ram_addr = 32'h10; bus.ram_writing = 1'b1; bus.ram_data = 8'hAB;
      @(negedge clk);
      chk("read-first old byte", {24'b0, bus.ram_loaded_data}, 32'h5A);
      bus.ram_writing = 1'b0;
      @(negedge clk);
      chk("read after write", {24'b0, bus.ram_loaded_data}, 32'hAB);

      // Status idle, unmapped/IO_DATA reads, ignored writes
      bus.ram_addr = IO_STATUS;
      @(negedge clk);
      chk("status idle", {24'b0, bus.ram_loaded_data}, 32'h00);
      bus.ram_addr = UNMAPPED;
      @(negedge clk);
      chk("unmapped read", {24'b0, bus.ram_loaded_data}, 32'h00);
      bus.ram_addr = IO_DATA;
      @(negedge clk);
      chk("io_data read", {24'b0, bus.ram_loaded_data}, 32'h00);
      bus.ram_addr = UNMAPPED; bus.ram_writing = 1'b1; bus.ram_data = 8'hFF;
      @(negedge clk);
      bus.ram_addr = IO_STATUS;
      @(negedge clk);
      bus.ram_writing = 1'b0; bus.ram_addr = 32'h0;
      @(negedge clk);
      chk("addr0 after unmapped write", {24'b0, bus.ram_loaded_data}, 32'h13);
      bus.ram_addr = IO_STATUS;
      @(negedge clk);
      chk("status after status write", {24'b0, bus.ram_loaded_data}, 32'h00);

      // One UART frame of 0x55; k counts edges after the push edge
      bus.ram_addr = IO_DATA; bus.ram_writing = 1'b1; bus.ram_data = 8'h55;
      for (int k = 0; k <= 170; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.ram_writing = 1'b0; bus.ram_addr = 32'h0;
            chk("tx_busy on push edge", {31'b0, bus.tx_busy}, 32'h1);
         end
         if (k == 1)  chk("uart idle during pop", {31'b0, bus.uart_tx}, 32'h1);
         if (k == 2)  chk("uart start first", {31'b0, bus.uart_tx}, 32'h0);
         if (k == 17) chk("uart start last", {31'b0, bus.uart_tx}, 32'h0);
         for (int b = 0; b < 8; b++)
            if (k == 18 + 16 * b + 8)
               chk($sformatf("uart 0x55 bit%0d", b), {31'b0, bus.uart_tx}, {31'b0, bits55[b]});
         if (k == 33)  chk("uart bit0 last cycle", {31'b0, bus.uart_tx}, 32'h1);
         if (k == 34)  chk("uart bit1 first cycle", {31'b0, bus.uart_tx}, 32'h0);
         if (k == 146) chk("uart stop", {31'b0, bus.uart_tx}, 32'h1);
         if (k == 160) chk("tx_busy last busy edge", {31'b0, bus.tx_busy}, 32'h1);
         if (k == 161) chk("tx_busy falls", {31'b0, bus.tx_busy}, 32'h0);
      end

      // Burst of 10 IO writes: the 9th fills the FIFO, the 10th is dropped
      for (int i = 0; i < 10; i++) begin
         bus.ram_addr = IO_DATA; bus.ram_writing = 1'b1; bus.ram_data = 8'hA0 + 8'(i);
         @(negedge clk);
         if (i == 7) chk("io_full after 8th write", {31'b0, bus.io_full}, 32'h0);
         if (i == 8) chk("io_full after 9th write", {31'b0, bus.io_full}, 32'h1);
      end
      bus.ram_writing = 1'b0; bus.ram_addr = IO_STATUS;
      @(negedge clk);
      chk("status after overflow", {24'b0, bus.ram_loaded_data}, 32'h07);

      // Let two frames finish, then reset during the third frame's data bits
      bus.ram_addr = 32'h0;
      repeat (370) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midframe reset uart_tx", {31'b0, bus.uart_tx}, 32'h1);
      chk("midframe reset tx_busy", {31'b0, bus.tx_busy}, 32'h0);
      chk("midframe reset io_full", {31'b0, bus.io_full}, 32'h0);
      chk("midread reset data", {24'b0, bus.ram_loaded_data}, 32'h00);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ram_addr = 32'(i);
         @(negedge clk);
         chk($sformatf("ram kept addr %0d", i), {24'b0, bus.ram_loaded_data}, {24'b0, pre[i]});
      end
      bus.ram_addr = 32'h10;
      @(negedge clk);
      chk("ram kept addr 0x10", {24'b0, bus.ram_loaded_data}, 32'hAB);
      bus.ram_addr = IO_STATUS;
      @(negedge clk);
      chk("status cleared by reset", {24'b0, bus.ram_loaded_data}, 32'h00);
      repeat (40) @(negedge clk);
      chk("line idle after reset", {31'b0, bus.uart_tx}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
